// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_seq
// Brief    : Sequential ALU control/execute unit. Decodes {alu_op, funct},
//            runs single-cycle ops, iterative MUL and bit-serial SLL, and
//            returns a registered result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_seq #(
    parameter int WIDTH   = 16,
    parameter int FUNCT_W = 4,
    parameter int MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               jr,
    output logic               illegal,
    output logic [2:0]         alu_ctrl
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_SLT = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MUL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_jr;
    logic             r_illegal;
    logic [2:0]       r_alu_ctrl;

    logic [2:0]         w_ctrl;
    logic               w_jr;
    logic               w_illegal;
    logic [FUNCT_W-1:0] w_funct_hi;
    logic [SH_W-1:0]    w_shamt;
    logic               w_multi;
    logic               w_accept;
    logic [WIDTH-1:0]   w_slt_res;
    logic [WIDTH-1:0]   w_single_res;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_funct_hi = funct >> 4;
    assign w_shamt    = b[SH_W-1:0];

    always_comb begin
        w_ctrl    = c_OP_ADD;
        w_jr      = 1'b0;
        w_illegal = 1'b0;
        case (alu_op)
            2'b11: w_ctrl = c_OP_ADD;
            2'b10: w_ctrl = c_OP_SLT;
            2'b01: w_ctrl = c_OP_SUB;
            default: begin
                if (w_funct_hi != '0) begin
                    w_illegal = 1'b1;
                end else begin
                    case (funct[3:0])
                        4'd0: w_ctrl = c_OP_ADD;
                        4'd1: w_ctrl = c_OP_SUB;
                        4'd2: w_ctrl = c_OP_AND;
                        4'd3: w_ctrl = c_OP_OR;
                        4'd4: w_ctrl = c_OP_SLT;
                        4'd5: begin
                            if (MUL_EN != 0) w_ctrl    = c_OP_MUL;
                            else             w_illegal = 1'b1;
                        end
                        4'd6: w_ctrl = c_OP_SLL;
                        4'd8: w_jr   = 1'b1;
                        default: w_illegal = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // Only MUL and non-zero shifts need the iterative datapath.
    assign w_multi = (w_ctrl == c_OP_MUL) || ((w_ctrl == c_OP_SLL) && (w_shamt != '0));

    assign w_slt_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};

    always_comb begin
        w_single_res = '0;
        if (w_illegal) begin
            w_single_res = '0;
        end else if (w_jr) begin
            w_single_res = a;
        end else begin
            case (w_ctrl)
                c_OP_ADD: w_single_res = a + b;
                c_OP_SUB: w_single_res = a - b;
                c_OP_AND: w_single_res = a & b;
                c_OP_OR:  w_single_res = a | b;
                c_OP_SLT: w_single_res = w_slt_res;
                c_OP_SLL: w_single_res = a;
                default:  w_single_res = '0;
            endcase
        end
    end

    always_comb begin
        w_acc_next = r_acc << 1;
        if (r_op == c_OP_MUL) begin
            w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        end
    end

    assign in_ready = !reset && ((r_state == c_ST_IDLE) ||
                                 ((r_state == c_ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_op       <= c_OP_ADD;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_jr       <= 1'b0;
            r_illegal  <= 1'b0;
            r_alu_ctrl <= c_OP_ADD;
        end else if (w_accept) begin
            r_op     <= w_ctrl;
            r_mcand  <= a;
            r_mplier <= b;
            if (w_multi) begin
                r_state <= c_ST_EXEC;
                if (w_ctrl == c_OP_MUL) begin
                    r_cnt <= c_CNT_MUL;
                    r_acc <= '0;
                end else begin
                    r_cnt <= {1'b0, w_shamt};
                    r_acc <= a;
                end
            end else begin
                r_state    <= c_ST_DONE;
                r_result   <= w_single_res;
                r_zero     <= (w_single_res == '0);
                r_jr       <= w_jr;
                r_illegal  <= w_illegal;
                r_alu_ctrl <= w_ctrl;
            end
        end else begin
            case (r_state)
                c_ST_EXEC: begin
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    // Output registers are only touched on the final iteration.
                    if (r_cnt == c_CNT_ONE) begin
                        r_state    <= c_ST_DONE;
                        r_result   <= w_acc_next;
                        r_zero     <= (w_acc_next == '0);
                        r_jr       <= 1'b0;
                        r_illegal  <= 1'b0;
                        r_alu_ctrl <= r_op;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) r_state <= c_ST_IDLE;
                end
                c_ST_IDLE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == c_ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign jr        = r_jr;
    assign illegal   = r_illegal;
    assign alu_ctrl  = r_alu_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_seq
// Brief    : Scoreboard bench for alu_control_seq with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_seq;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         jr;
        logic         illegal;
        logic [2:0]   ctrl;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [1:0]   alu_op = '0;
    logic [3:0]   funct = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         jr;
    logic         illegal;
    logic [2:0]   alu_ctrl;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_control_seq #(.WIDTH(W), .FUNCT_W(4), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .jr(jr), .illegal(illegal), .alu_ctrl(alu_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [W-1:0] r, logic z, logic j, logic il, logic [2:0] c);
        exp_t e;
        e.result = r; e.zero = z; e.jr = j; e.illegal = il; e.ctrl = c;
        return e;
    endfunction

    // Monitor: every completed output handshake is matched against the queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                m_e = q.pop_front();
                check("txn {result,zero,jr,illegal,ctrl}",
                      {10'b0, result, zero, jr, illegal, alu_ctrl}, {10'b0, m_e});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] f,
                         input logic [W-1:0] va, input logic [W-1:0] vb, input logic rdy);
        @(posedge clk); #1;
        alu_op = op; funct = f; a = va; b = vb; out_ready = rdy; in_valid = 1'b1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int busy);
        lat = 0; busy = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            if (!in_ready) busy++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [3:0] f,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input exp_t e, input int exp_lat, input int exp_busy);
        int lat, busy;
        q.push_back(e);
        issue(op, f, va, vb, 1'b1);
        wait_out(lat, busy);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, busy, exp_busy);
    endtask

    initial begin
        int   lat, busy, highs;
        exp_t snap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_reset", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_values", {8'b0, in_ready, out_valid, result, zero, jr, illegal, alu_ctrl},
              {8'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000});

        run("sub",      2'b00, 4'd1, 16'd5,     16'd7,     mk(16'hFFFE, 0, 0, 0, 3'b001), 1, 0);
        run("mul",      2'b00, 4'd5, 16'd300,   16'd300,   mk(16'h5F90, 0, 0, 0, 3'b101), 17, 16);
        run("mul_neg",  2'b00, 4'd5, 16'hFFFF,  16'd3,     mk(16'hFFFD, 0, 0, 0, 3'b101), 17, 16);
        run("sll4",     2'b00, 4'd6, 16'h0003,  16'd4,     mk(16'h0030, 0, 0, 0, 3'b110), 5, 4);
        run("sll0",     2'b00, 4'd6, 16'h0003,  16'd0,     mk(16'h0003, 0, 0, 0, 3'b110), 1, 0);
        run("sll15",    2'b00, 4'd6, 16'h0001,  16'd15,    mk(16'h8000, 0, 0, 0, 3'b110), 16, 15);
        run("jr",       2'b00, 4'd8, 16'h1234,  16'd5,     mk(16'h1234, 0, 1, 0, 3'b000), 1, 0);
        run("illegal9", 2'b00, 4'd9, 16'h1234,  16'd5,     mk(16'h0000, 1, 0, 1, 3'b000), 1, 0);
        run("illegal7", 2'b00, 4'd7, 16'h00FF,  16'd1,     mk(16'h0000, 1, 0, 1, 3'b000), 1, 0);
        run("and",      2'b00, 4'd2, 16'hF0F0,  16'hFF00,  mk(16'hF000, 0, 0, 0, 3'b010), 1, 0);
        run("or",       2'b00, 4'd3, 16'hF0F0,  16'hFF00,  mk(16'hFFF0, 0, 0, 0, 3'b011), 1, 0);
        run("branch",   2'b01, 4'd7, 16'd9,     16'd9,     mk(16'h0000, 1, 0, 0, 3'b001), 1, 0);
        run("slt_pos",  2'b00, 4'd4, 16'd1,     16'hFFFF,  mk(16'h0000, 1, 0, 0, 3'b100), 1, 0);
        run("add_wrap", 2'b11, 4'd0, 16'hFFFF,  16'd2,     mk(16'h0001, 0, 0, 0, 3'b000), 1, 0);

        // Back-pressure on an SLT result, then a same-cycle accept.
        q.push_back(mk(16'h0001, 0, 0, 0, 3'b100));
        issue(2'b10, 4'd0, 16'hFFFF, 16'd1, 1'b0);
        wait_out(lat, busy);
        check("slt_bp_latency", lat, 1);
        snap = mk(result, zero, jr, illegal, alu_ctrl);
        check("slt_bp_first_value", {10'b0, snap}, {10'b0, mk(16'h0001, 0, 0, 0, 3'b100)});
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {9'b0, out_valid, result, zero, jr, illegal, alu_ctrl},
                  {9'b0, 1'b1, snap});
        end
        @(posedge clk); #1;
        q.push_back(mk(16'h0005, 0, 0, 0, 3'b000));
        alu_op = 2'b11; funct = 4'd0; a = 16'd2; b = 16'd3;
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat, busy);
        check("b2b_latency", lat, 1);

        // Reset in the middle of a MUL.
        issue(2'b00, 4'd5, 16'd300, 16'd300, 1'b1);
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) highs++;
            @(posedge clk);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        check("in_ready_mid_reset", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_values", {8'b0, in_ready, out_valid, result, zero, jr, illegal, alu_ctrl},
              {8'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000});
        repeat (25) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        check("aborted_mul_out_valid_count", highs, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
